// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry and arbiter state encoding
package fb_pkg;

  localparam int FB_ADDR_W = 14;               // 128x128 words
  localparam int FB_DATA_W = 12;               // {B,G,R} 4 bits each
  localparam int FB_WORDS  = 1 << FB_ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - three-port arbiter (video > clear > writer) for a single-port framebuffer BRAM
//
// Ports:
//   clk_25mhz, reset_n          : clock, asynchronous active-low reset (release synchronised)
//   vid_req/vid_addr            : video read request, never stalled, granted combinationally
//   vid_rdata/vid_rvalid        : read data one cycle after vid_req
//   wr_valid/wr_ready/wr_addr/wr_data : writer handshake, lowest priority
//   clr_start/clr_color         : start a full-buffer fill with clr_color
//   clr_busy/clr_done           : fill in progress / one-cycle completion pulse
//   mem_addr/mem_we/mem_wdata/mem_rdata : external BRAM, 1-cycle registered read
//   wr_stall_cnt                : saturating count of writer stall cycles
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       wr_stall_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  fb_state_e         state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] clr_col;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic              clr_grant;
  logic              wr_grant;

  // Assert immediately, release two edges after reset_n rises.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign clr_busy  = (state == CLEAR);
  // rst_int_n keeps the writer locked out until the FSM is out of reset.
  assign wr_ready  = rst_int_n && (state == IDLE) && !vid_req && !clr_start;
  assign clr_grant = (state == CLEAR) && !vid_req;
  assign wr_grant  = wr_ready && wr_valid;
  assign vid_rdata = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vid_req) begin
      mem_addr = vid_addr;
    end else if (clr_grant) begin
      mem_addr  = clr_ptr;
      mem_we    = 1'b1;
      mem_wdata = clr_col;
    end else if (wr_grant) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      clr_ptr  <= '0;
      clr_col  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            clr_col <= clr_color;
            clr_ptr <= '0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          // A video cycle steals the port; the pointer simply waits.
          if (!vid_req) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == LAST_ADDR) begin
              state    <= IDLE;
              clr_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      vid_rvalid   <= 1'b0;
      wr_stall_cnt <= 16'h0000;
    end else begin
      vid_rvalid <= vid_req;
      if (wr_valid && !wr_ready && wr_stall_cnt != 16'hFFFF)
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning framebuffer word address width (128x128 pixels).
REQ-002 SHALL have parameter DATA_W, default 12, meaning pixel width ({B,G,R}, 4 bits each).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk_25mhz, input, 1 bit, the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port vid_req, input, 1 bit, video scanout read request, valid every cycle it is high.
REQ-007 SHALL have port vid_addr, input, ADDR_W bits, video read address ({row[6:0],col[6:0]}).
REQ-008 SHALL have port vid_rdata, output, DATA_W bits, pixel returned to video.
REQ-009 SHALL have port vid_rvalid, output, 1 bit, vid_rdata is valid this cycle.
REQ-010 SHALL have port wr_valid, input, 1 bit, writer request.
REQ-011 SHALL have port wr_ready, output, 1 bit, writer request accepted this cycle.
REQ-012 SHALL have port wr_addr, input, ADDR_W bits, writer address.
REQ-013 SHALL have port wr_data, input, DATA_W bits, writer pixel.
REQ-014 SHALL have port clr_start, input, 1 bit, single-cycle pulse that starts a full-buffer clear.
REQ-015 SHALL have port clr_color, input, DATA_W bits, fill colour, sampled on the clr_start cycle.
REQ-016 SHALL have port clr_busy, output, 1 bit, a clear is in progress.
REQ-017 SHALL have port clr_done, output, 1 bit, one-cycle pulse when a clear completes.
REQ-018 SHALL have ports mem_addr (output, ADDR_W bits), mem_we (output, 1 bit), mem_wdata (output, DATA_W bits) and mem_rdata (input, DATA_W bits), driving a single-port BRAM with 1-cycle registered read.
REQ-019 SHALL have port wr_stall_cnt, output, 16 bits, saturating count of cycles with wr_valid=1 and wr_ready=0.

Function
REQ-020 Port priority SHALL be, highest first: video, clear, writer.
REQ-021 When vid_req=1, the block SHALL drive mem_addr=vid_addr and mem_we=0 in the same cycle (combinational grant).
REQ-022 vid_rvalid SHALL be vid_req delayed by exactly one cycle, with vid_rdata=mem_rdata in that cycle; video SHALL never be stalled.
REQ-023 The FSM SHALL have the states IDLE and CLEAR.
REQ-024 In IDLE, clr_start=1 SHALL latch clr_color, zero the 14-bit clear pointer and move the FSM to CLEAR on the next edge.
REQ-025 In CLEAR with vid_req=0, the block SHALL write the latched colour at the pointer and increment the pointer.
REQ-026 In CLEAR with vid_req=1, the pointer SHALL hold.
REQ-027 Writing the last address (2^ADDR_W-1) SHALL return the FSM to IDLE and pulse clr_done for one cycle; the pointer wraps to 0.
REQ-028 clr_busy SHALL equal (state==CLEAR).
REQ-029 clr_start while in CLEAR SHALL be ignored; it does not restart the clear or change the colour.
REQ-030 wr_ready SHALL equal (state==IDLE && !vid_req && !clr_start).
REQ-031 A write SHALL occur when wr_valid && wr_ready: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data in that cycle.
REQ-032 The writer SHALL hold wr_addr and wr_data stable while wr_valid=1 and wr_ready=0.
REQ-033 Simultaneous clr_start and wr_valid in IDLE SHALL give the clear priority: no write that cycle.
REQ-034 mem_we SHALL be 0 in every cycle without a clear or writer grant; mem_addr is then don't-care and the block SHALL drive 0.
REQ-035 wr_stall_cnt SHALL increment by 1 per stalled cycle and saturate at 16'hFFFF.

Reset
REQ-036 While reset_n=0, outputs SHALL be: state=IDLE, vid_rvalid=0, clr_busy=0, clr_done=0, wr_stall_cnt=0, wr_ready=0, mem_we=0.
REQ-037 Reset asserted mid-clear SHALL abort the clear with no clr_done pulse; the partially written buffer is left as is.
REQ-038 Release of reset_n SHALL be synchronised internally (two-flop deassert) before the FSM leaves reset.

Structure
REQ-039 The package fb_pkg SHALL hold FB_ADDR_W, FB_DATA_W, FB_WORDS and the state encoding (IDLE=0, CLEAR=1).
REQ-040 The design SHALL be a single module with no sub-modules; the BRAM stays external.

Verification
REQ-041 Video only: vid_req=1 with vid_addr 0x0000..0x007F, memory preloaded with data=addr -> vid_rvalid one cycle later, vid_rdata=addr[11:0], mem_we=0 throughout.
REQ-042 Write stall: wr_valid=1, addr 0x1234, data 0xF00, vid_req high for 5 cycles -> wr_ready=0 for 5 cycles, write on cycle 6, wr_stall_cnt=5.
REQ-043 Clear: clr_start with colour 0x444, vid_req=0 -> exactly 16384 writes of 0x444, clr_done on the final write+1 edge, clr_busy low after.
REQ-044 Clear interleaved with video: vid_req pattern 50% duty during clear -> no pointer skips or duplicates, readback all 0x444, ~32768 cycles.
REQ-045 Simultaneous events: clr_start and wr_valid in the same cycle -> no write, clear begins; a second clr_start mid-clear -> ignored.
REQ-046 Reset mid-clear at pointer 100 -> clr_busy=0 immediately, no clr_done, wr_stall_cnt=0.
